// File: rtl/bp_update_queue.sv
// bp_update_queue: FIFO between branch resolution and the PHT update port.
// Drains one update per cycle as a single-cycle write and repairs the local
// history pattern when consecutive updates hit the same PHT index, so that
// chained same-index updates train on the true history.
// Optional feature macro: BP_UPDATE_BYPASS_EN (0-cycle bypass when empty).

module bp_update_queue #(
    parameter int DEPTH     = 8,
    parameter int PHT_IDX_W = 5,
    parameter int LHT_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PHT_IDX_W-1:0]   in_pht_idx,
    input  logic                   in_taken,
    input  logic [1:0]             in_prev_state,
    input  logic [LHT_IDX_W-1:0]   in_prev_pattern,
    input  logic                   hold,
    output logic                   pht_we,
    output logic [PHT_IDX_W-1:0]   pht_idx,
    output logic                   pht_taken,
    output logic [1:0]             pht_prev_state,
    output logic [LHT_IDX_W-1:0]   pht_prev_pattern,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [PHT_IDX_W-1:0] idx;
        logic                 taken;
        logic [1:0]           prev_state;
        logic [LHT_IDX_W-1:0] prev_pattern;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [AW-1:0]        head;
    logic [AW-1:0]        tail;
    logic [CW-1:0]        count_q;

    entry_t               in_entry;
    entry_t               src;
    logic                 enq;
    logic                 deq;
    logic                 bypass;
    logic                 fire;

    logic                 last_vld;
    logic [PHT_IDX_W-1:0] last_idx;
    logic [LHT_IDX_W-1:0] last_pat;
    logic [LHT_IDX_W-1:0] out_pattern;

    assign in_entry = {in_pht_idx, in_taken, in_prev_state, in_prev_pattern};

    // A full queue never accepts, even if it drains in the same cycle.
    assign in_ready = (count_q != FULL);
    assign deq      = (count_q != '0) && !hold;

`ifdef BP_UPDATE_BYPASS_EN
    // Empty queue with a live input: hand it straight to the PHT port.
    // Gated with rst_n so no write can escape while reset is asserted.
    assign bypass = rst_n && (count_q == '0) && in_valid && !hold;
`else
    assign bypass = 1'b0;
`endif

    assign enq  = in_valid && in_ready && !bypass;
    assign fire = deq || bypass;
    assign src  = bypass ? in_entry : mem[head];

    // Repaired pattern: the previous write to this index already shifted in
    // its outcome, which the entry's prediction-time pattern did not see.
    assign out_pattern = (last_vld && (src.idx == last_idx)) ? last_pat
                                                             : src.prev_pattern;

    assign count = count_q;

    // Drive the PHT update port from the selected entry; zero when idle.
    always_comb begin
        pht_we           = 1'b0;
        pht_idx          = '0;
        pht_taken        = 1'b0;
        pht_prev_state   = '0;
        pht_prev_pattern = '0;
        if (fire) begin
            pht_we           = 1'b1;
            pht_idx          = src.idx;
            pht_taken        = src.taken;
            pht_prev_state   = src.prev_state;
            pht_prev_pattern = out_pattern;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= in_entry;
        end
    end

    // Pointer and occupancy bookkeeping; count is kept independently of the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                tail <= tail + AW'(1);
            end
            if (deq) begin
                head <= head + AW'(1);
            end
            unique case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Remember the history each write leaves behind; survives hold and idle periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld <= 1'b0;
            last_idx <= '0;
            last_pat <= '0;
        end else if (fire) begin
            last_vld <= 1'b1;
            last_idx <= src.idx;
            last_pat <= {out_pattern[LHT_IDX_W-2:0], src.taken};
        end
    end

endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- Sits between the execute-stage branch resolution logic and the pattern-history-table update port.
- Buffers resolved-branch outcomes in a FIFO and drains at most one update per cycle as a single-cycle write (pht_we plus fields).
- Repairs stale local-history patterns when back-to-back updates target the same PHT index, so the PHT/LHT chain trains on the true history.

Parameters:
- DEPTH, 8, number of queued updates; power of 2, >= 2.
- PHT_IDX_W, 5, PHT index width; equals $clog2(PHT_DEPTH).
- LHT_IDX_W, 4, local pattern width; equals $clog2(LHT_DEPTH); >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  resolved branch update offered by execute.
- in_ready  out  1  queue can accept; an update transfers when in_valid && in_ready.
- in_pht_idx  in  PHT_IDX_W  PHT index of the resolved branch.
- in_taken  in  1  resolved direction.
- in_prev_state  in  2  bp_state_t counter value read at prediction time.
- in_prev_pattern  in  LHT_IDX_W  pattern read at prediction time.
- hold  in  1  suppress draining this cycle; enqueue still allowed.
- pht_we  out  1  one-cycle update strobe to PHT.
- pht_idx  out  PHT_IDX_W  update index.
- pht_taken  out  1  update direction.
- pht_prev_state  out  2  counter value for LHT update.
- pht_prev_pattern  out  LHT_IDX_W  history pattern; repaired when needed.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): head=tail=0, count=0, last_vld=0. Outputs: pht_we=0, count=0, in_ready=1, all data outputs 0.
- Storage: circular buffer, head/tail pointers wrap modulo DEPTH. count is a separate register, not derived from the pointers.
- in_ready = (count != DEPTH). This is combinational from count only; a full queue does not accept even when draining in the same cycle.
- Drain condition: deq = (count != 0) && !hold.
  - pht_we = deq.
  - Data outputs come combinationally from the head entry.
  - With pht_we=0, all data outputs are driven 0.
- Latency: an update enqueued at edge N is visible on pht_we at the earliest in cycle N+1 (after edge N), if the queue was empty and hold=0.
- Simultaneous enq and deq: count unchanged, both pointers advance. Order is strictly FIFO.
- Pattern repair register (last_vld, last_idx, last_pat):
  - On every deq: last_idx <= head.idx, last_pat <= {out_pattern[LHT_IDX_W-2:0], head.taken}, last_vld <= 1.
  - If last_vld && head.idx == last_idx, then pht_prev_pattern = last_pat; otherwise pht_prev_pattern = head.prev_pattern.
  - out_pattern is the value actually driven on pht_prev_pattern, so repair chains across three or more same-index updates.
  - last_* persist through hold and through empty periods. Only reset clears them.
- pht_prev_state passes through unrepaired.
- Hold while full: in_ready=0, no state change.
- Reset mid-operation: all queued updates are discarded immediately. No partial write: pht_we drops asynchronously with rst_n.

Optional Feature:
- Macro BP_UPDATE_BYPASS_EN.
- Defined: when count==0 && in_valid && !hold, the input is presented on pht_* in the same cycle with pht_we=1 and is not written to the queue (0-cycle latency). Repair applies to bypassed data, and last_* update as for a normal drain.
- Undefined: minimum latency is 1 cycle as described above.

Test Plan:
- Reset/idle: rst_n=0 then 1 with no input -> pht_we=0, count=0, in_ready=1 for 10 cycles.
- Single update: enqueue idx=5, taken=1, state=2'b10, pattern=4'b0011 -> next cycle pht_we=1, idx=5, taken=1, prev_state=2'b10, prev_pattern=4'b0011; count 1->0. With BP_UPDATE_BYPASS_EN, pht_we=1 in the same cycle instead.
- Fill/backpressure: hold=1, enqueue 9 updates idx=0..8 -> count=8, in_ready=0, 9th not accepted. Release hold -> 8 strobes, idx 0..7 in order, wrap correct.
- Same-index repair: enqueue idx=3 taken=1 pat=4'b0000, then idx=3 taken=0 pat=4'b0000, then idx=3 taken=1 pat=4'b0000 -> outputs pat 4'b0000, 4'b0001, 4'b0010.
- Repair only on match: idx=3 pat=4'b0101, then idx=4 pat=4'b1111 -> second output pattern 4'b1111, unrepaired.
- Async reset mid-drain: 4 entries queued, assert rst_n low mid-cycle -> pht_we falls before next edge. After release count=0 and last_vld=0: next idx=3 update is not repaired.
